// File: rtl/flip_rt_pkg.sv
// Types and constants shared by the out_flip_rt transmitter and its matching receiver.
// Default payload width, buffer depth and the pointer-width helper.
package flip_rt_pkg;

    localparam int FLIP_RT_WIDTH = 32;
    localparam int FLIP_RT_CNT   = 4;

    typedef logic [FLIP_RT_WIDTH-1:0] flip_word_t;

    // Depths are powers of two, so the pointers wrap naturally at CNT.
    function automatic int ptr_w(input int cnt);
        return (cnt < 2) ? 1 : $clog2(cnt);
    endfunction

    localparam int FLIP_RT_PTR_W = ptr_w(FLIP_RT_CNT);

endpackage

// File: rtl/flip_rt_fifo_mem.sv
// CNT x WIDTH register array for the out_flip_rt buffer.
// It has one write port and an asynchronous read port, so the head entry is visible in the same cycle.
module flip_rt_fifo_mem
    import flip_rt_pkg::*;
#(
    parameter int WIDTH = FLIP_RT_WIDTH,
    parameter int CNT   = FLIP_RT_CNT,
    parameter int PW    = ptr_w(CNT)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [PW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [CNT];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/out_flip_rt.sv
// Transmit side of the flip link. A CNT-deep in-order buffer issues words to a receiver
// that pauses through a registered rx_pause. Optional same-cycle bypass: OUT_FLIP_RT_BYPASS_EN.
module out_flip_rt
    import flip_rt_pkg::*;
#(
    parameter int WIDTH = $bits(flip_word_t),
    parameter int CNT   = FLIP_RT_CNT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             src_ready,
    output logic             tx_en,
    output logic [WIDTH-1:0] tx_data,
    input  logic             rx_pause,
    output logic             idle,
    output logic [15:0]      tx_count
);

    localparam int PW = ptr_w(CNT);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] OCC_FULL = OW'(CNT);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic             pause_q, pause_d;
    logic [15:0]      tx_count_q, tx_count_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic [WIDTH-1:0] head_data;
    logic             empty, full, push, pop, bypass, issue;

    flip_rt_fifo_mem #(
        .WIDTH (WIDTH),
        .CNT   (CNT),
        .PW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (src_data),
        .raddr (rd_ptr_q),
        .rdata (head_data)
    );

    always_comb begin
        empty = (occ_q == '0);
        full  = (occ_q == OCC_FULL);
`ifdef OUT_FLIP_RT_BYPASS_EN
        bypass = !rst && empty && !pause_q && src_valid;
`else
        bypass = 1'b0;
`endif
        // Reset blocks issue outright, so a mid-stream reset never leaks a word.
        pop   = !rst && !empty && !pause_q;
        issue = pop || bypass;
        push  = !rst && src_valid && !full && !bypass;

        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        occ_d      = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (!push && pop) begin
            occ_d = occ_q - 1'b1;
        end
        pause_d    = rx_pause;
        tx_count_d = tx_count_q + {15'd0, issue};
        last_d     = issue ? (bypass ? src_data : head_data) : last_q;

        if (rst) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            occ_d      = '0;
            pause_d    = 1'b0;
            tx_count_d = '0;
        end
    end

    always_comb begin
        src_ready = rst || !full;
        tx_en     = issue;
        tx_data   = last_d;
        idle      = rst || (empty && !issue);
        tx_count  = rst ? 16'd0 : tx_count_q;
    end

    always_ff @(posedge clk) begin
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        occ_q      <= occ_d;
        pause_q    <= pause_d;
        tx_count_q <= tx_count_d;
        last_q     <= last_d;
    end

endmodule
